// File: rtl/c_shared_fifo_sched_pkg.sv
// Shared definitions for the shared-buffer FIFO scheduler: width helper and error bit indices.
package c_shared_fifo_sched_pkg;

  localparam int ERR_BAD_SEL  = 0;
  localparam int ERR_OVERFLOW = 1;

  // Ceiling log2 with a minimum of 1 bit so single-entry widths never collapse to zero.
  function automatic int clogb(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/c_shared_fifo_sched_rr.sv
// Round-robin pointer plus wrap-around priority search: grants the first requester at or
// after the pointer; the pointer moves past the grant only when advance is asserted.
module c_shared_fifo_sched_rr #(
  parameter int num_queues = 4,
  parameter int qidx_width = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [num_queues-1:0] req,
  input  logic                  advance,
  output logic [qidx_width-1:0] gnt_idx,
  output logic                  any_req
);

  logic [qidx_width-1:0] ptr;

  // Walk offsets from the far end down to zero so the nearest requester wins.
  always_comb begin
    gnt_idx = ptr;
    for (int k = num_queues - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= num_queues) idx = idx - num_queues;
      if (req[idx]) gnt_idx = qidx_width'(idx);
    end
  end

  assign any_req = |req;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      if (32'(gnt_idx) == num_queues - 1) ptr <= '0;
      else                                ptr <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/c_shared_fifo_sched.sv
// Head/tail/occupancy controller for a buffer RAM split into num_queues static FIFO regions.
// Optional error reporting is enabled with the C_SHARED_FIFO_SCHED_ERRCHK_EN macro.
module c_shared_fifo_sched
  import c_shared_fifo_sched_pkg::*;
#(
  parameter  int num_queues = 4,
  parameter  int depth      = 8,
  localparam int qidx_width = clogb(num_queues),
  localparam int ptr_width  = clogb(depth),
  localparam int addr_width = qidx_width + ptr_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [qidx_width-1:0] push_sel,
  output logic [addr_width-1:0] push_addr,
  output logic                  push_ack,
  input  logic                  pop_ready,
  output logic                  pop_valid,
  output logic [qidx_width-1:0] pop_sel,
  output logic [addr_width-1:0] pop_addr,
  output logic [num_queues-1:0] empty,
  output logic [num_queues-1:0] full,
  output logic [1:0]            errors
);

  localparam int cnt_width = ptr_width + 1;

  logic [ptr_width-1:0] head_q [num_queues];
  logic [ptr_width-1:0] tail_q [num_queues];
  logic                 sel_ok, full_sel, pop_fire, any_req;

  // Handshakes: a push transfers when push_ack is high (the RAM write strobe); a pop
  // transfers when pop_valid & pop_ready are both high in the same cycle.
  assign sel_ok    = 32'(push_sel) < num_queues;
  assign full_sel  = sel_ok && full[push_sel];
  assign push_ack  = !reset && push_valid && sel_ok && !full_sel;
  assign push_addr = {push_sel, tail_q[push_sel]};

  assign pop_valid = !reset && any_req;
  assign pop_fire  = pop_valid && pop_ready;
  assign pop_addr  = {pop_sel, head_q[pop_sel]};

  c_shared_fifo_sched_rr #(
    .num_queues(num_queues),
    .qidx_width(qidx_width)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (~empty),
    .advance(pop_fire),
    .gnt_idx(pop_sel),
    .any_req(any_req)
  );

  for (genvar q = 0; q < num_queues; q++) begin : g_queue
    logic                 do_push, do_pop, empty_r, full_r;
    logic [cnt_width-1:0] count_r, count_next;
    logic [ptr_width-1:0] head_r, tail_r;

    assign do_push    = push_ack && (push_sel == qidx_width'(q));
    assign do_pop     = pop_fire && (pop_sel == qidx_width'(q));
    assign count_next = count_r + cnt_width'(do_push) - cnt_width'(do_pop);

    // Pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
      if (reset) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
        empty_r <= 1'b1;
        full_r  <= 1'b0;
      end else begin
        if (do_push) tail_r <= tail_r + 1'b1;
        if (do_pop)  head_r <= head_r + 1'b1;
        count_r <= count_next;
        empty_r <= (count_next == '0);
        full_r  <= (count_next == cnt_width'(depth));
      end
    end

    assign head_q[q] = head_r;
    assign tail_q[q] = tail_r;
    assign empty[q]  = empty_r;
    assign full[q]   = full_r;
  end

  always_comb begin
    errors = '0;
`ifdef C_SHARED_FIFO_SCHED_ERRCHK_EN
    errors[ERR_BAD_SEL]  = push_valid && !sel_ok;
    errors[ERR_OVERFLOW] = push_valid && full_sel;
`else
    errors[ERR_BAD_SEL]  = 1'b0;
    errors[ERR_OVERFLOW] = 1'b0;
`endif
  end

endmodule
